// File: rtl/icache_nway_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : icache_nway_ctrl
// Purpose  : N-way set-associative read-only instruction cache controller with
//            round-robin replacement, rid filtering and whole-cache invalidate.
//            Optional hit/miss counters are enabled by ICACHE_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module icache_nway_ctrl #(
  parameter int LINE_WORDS = 8,
  parameter int SETS       = 128,
  parameter int WAYS       = 2,
  parameter int AXI_ID     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        inval,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int OFF_W = $clog2(LINE_WORDS) + 2;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - OFF_W - IDX_W;
  localparam int WRD_W = $clog2(LINE_WORDS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_MISS   = 2'd2,
    S_REFILL = 2'd3
  } state_t;

  state_t            state_q;
  logic [31:0]       req_addr_q;
  logic [WAY_W-1:0]  victim_q;
  logic [WRD_W-1:0]  beat_cnt_q;
  logic              inval_pend_q;

  logic              valid_q [WAYS][SETS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [31:0]       data_q  [WAYS][SETS][LINE_WORDS];

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WRD_W-1:0]  req_word;
  logic [WAY_W-1:0]  rr_victim;
  logic              hit;
  logic [31:0]       hit_word;
  logic              lookup_hit;
  logic              beat_acc;
  logic              refill_done;
  logic              clear_all;
  logic              unused_bits;

  assign req_idx  = req_addr_q[OFF_W+IDX_W-1:OFF_W];
  assign req_tag  = req_addr_q[31:OFF_W+IDX_W];
  assign req_word = req_addr_q[OFF_W-1:2];
  assign unused_bits = ^req_addr_q[1:0];

  // Only valid ways take part; at most one way can match, so OR-ing is a mux.
  always_comb begin
    hit      = 1'b0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit      = 1'b1;
        hit_word = hit_word | data_q[w][req_idx][req_word];
      end
    end
  end

  assign lookup_hit  = !rst && (state_q == S_LOOKUP) && hit;
  assign beat_acc    = (state_q == S_REFILL) && rvalid && (rid == 4'(AXI_ID));
  assign refill_done = beat_acc && rlast;
  assign clear_all   = (inval && ((state_q == S_IDLE) || (state_q == S_LOOKUP))) ||
                       (refill_done && (inval_pend_q || inval));

  assign inst_addr_ok = !rst && !inval && inst_req && ((state_q == S_IDLE) || lookup_hit);
  assign inst_data_ok = lookup_hit;
  assign inst_rdata   = lookup_hit ? hit_word : 32'd0;

  assign arid    = 4'(AXI_ID);
  assign araddr  = {req_addr_q[31:OFF_W], {OFF_W{1'b0}}};
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = 3'd2;
  assign arburst = 2'b01;
  assign arvalid = !rst && (state_q == S_MISS);
  assign rready  = !rst && (state_q == S_REFILL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_addr_q   <= '0;
      victim_q     <= '0;
      beat_cnt_q   <= '0;
      inval_pend_q <= 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[w][s] <= 1'b0;
        end
      end
    end else begin
      if (inst_addr_ok) begin
        req_addr_q <= inst_addr;
      end
      case (state_q)
        S_IDLE: begin
          if (inst_addr_ok) begin
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            state_q <= inst_addr_ok ? S_LOOKUP : S_IDLE;
          end else begin
            state_q  <= S_MISS;
            victim_q <= rr_victim;
          end
        end
        S_MISS: begin
          if (inval) begin
            inval_pend_q <= 1'b1;
          end
          if (arready) begin
            state_q <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (beat_acc) begin
            beat_cnt_q <= beat_cnt_q + WRD_W'(1);
          end
          if (refill_done) begin
            beat_cnt_q   <= '0;
            inval_pend_q <= 1'b0;
            state_q      <= S_LOOKUP;
            valid_q[victim_q][req_idx] <= 1'b1;
          end else if (inval) begin
            inval_pend_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // Placed last so a pending invalidate also drops the line just refilled.
      if (clear_all) begin
        for (int w = 0; w < WAYS; w++) begin
          for (int s = 0; s < SETS; s++) begin
            valid_q[w][s] <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat_acc) begin
      data_q[victim_q][req_idx][beat_cnt_q] <= rdata;
    end
    if (refill_done) begin
      tag_q[victim_q][req_idx] <= req_tag;
    end
  end

  generate
    if (WAYS > 1) begin : g_rr
      logic [WAY_W-1:0] rr_ptr_q [SETS];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < SETS; s++) begin
            rr_ptr_q[s] <= '0;
          end
        end else if (refill_done) begin
          rr_ptr_q[req_idx] <= rr_ptr_q[req_idx] + WAY_W'(1);
        end
      end
      assign rr_victim = rr_ptr_q[req_idx];
    end else begin : g_rr_none
      assign rr_victim = '0;
    end
  endgenerate

`ifdef ICACHE_PERF_CNT_EN
  logic        relookup_q;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // The lookup right after a refill is the original miss completing, not a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      relookup_q <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      relookup_q <= refill_done;
      if ((state_q == S_LOOKUP) && hit && !relookup_q && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if ((state_q == S_LOOKUP) && !hit && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = 32'd0;
  assign miss_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_nway_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_nway_ctrl
// Purpose  : Directed table-driven and sequence bench for icache_nway_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_icache_nway_ctrl;

  localparam int LW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        inval;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  icache_nway_ctrl #(.LINE_WORDS(LW), .SETS(128), .WAYS(2), .AXI_ID(3)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inval(inval),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        arready;
    logic        rvalid;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;
    logic        e_addr_ok;
    logic        e_data_ok;
    logic [31:0] e_rdata;
    logic        e_arvalid;
    logic [31:0] e_araddr;
    logic        e_rready;
  } vec_t;

  vec_t vt[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 1'b0; inst_addr = '0; inval = 1'b0; arready = 1'b0;
    rvalid = 1'b0; rid = '0; rdata = '0; rlast = 1'b0;
  endtask

  function automatic vec_t mkv(logic req, logic [31:0] addr, logic ar_rdy, logic rv, logic [3:0] id,
                               logic [31:0] d, logic last, logic e_aok, logic e_dok,
                               logic [31:0] e_rd, logic e_arv, logic [31:0] e_ara, logic e_rr);
    vec_t v;
    v.req = req; v.addr = addr; v.arready = ar_rdy; v.rvalid = rv; v.rid = id; v.rdata = d;
    v.rlast = last; v.e_addr_ok = e_aok; v.e_data_ok = e_dok; v.e_rdata = e_rd;
    v.e_arvalid = e_arv; v.e_araddr = e_ara; v.e_rready = e_rr;
    return v;
  endfunction

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    inst_req = 1'b1;
    inst_addr = 32'h1000_0040;
    step();
    @(negedge clk);
    check("reset_outputs", {inst_addr_ok, inst_data_ok, arvalid, rready, inst_rdata}, 36'd0);
    step();
    rst = 1'b0;
    inst_req = 1'b0;
    @(negedge clk);
    check("post_reset_cnt", {hit_cnt, miss_cnt}, 64'd0);
    step();
  endtask

  // Bounded wait for the AR request, then one-cycle handshake.
  task automatic wait_ar(input logic [31:0] a);
    int n;
    n = 0;
    @(negedge clk);
    while (!arvalid && n < 10) begin
      step();
      @(negedge clk);
      n++;
    end
    check("ar_issue", {arvalid, araddr}, {1'b1, a & 32'hFFFF_FFE0});
    arready = 1'b1;
    step();
    arready = 1'b0;
  endtask

  task automatic refill(input logic [31:0] base, input bit foreign, input bit inval_mid);
    int k;
    int beats;
    k = 0;
    beats = foreign ? LW + 1 : LW;
    for (int c = 0; c < beats; c++) begin
      rvalid = 1'b1;
      inval = inval_mid && (c == 2);
      if (foreign && c == 3) begin
        rid = 4'd5; rdata = 32'hDEAD_BEEF; rlast = 1'b0;
      end else begin
        rid = 4'd3; rdata = base + 32'(k); rlast = (k == LW - 1); k++;
      end
      @(negedge clk);
      if (foreign && c == 3) check("rready_foreign", rready, 1'b1);
      step();
    end
    rvalid = 1'b0; rlast = 1'b0; rid = '0; rdata = '0; inval = 1'b0;
  endtask

  task automatic access(input logic [31:0] a, input bit exp_miss, input logic [31:0] base,
                        input bit foreign, input bit inval_mid);
    logic [31:0] exp_word;
    exp_word = base + ((a >> 2) & 32'h7);
    inst_req = 1'b1;
    inst_addr = a;
    @(negedge clk);
    check("addr_ok", inst_addr_ok, 1'b1);
    step();
    inst_req = 1'b0;
    @(negedge clk);
    check("hit_or_miss", !inst_data_ok, exp_miss);
    if (inst_data_ok) begin
      check("hit_data", inst_rdata, exp_word);
      step();
    end else begin
      step();
      wait_ar(a);
      refill(base, foreign, inval_mid);
      if (inval_mid) begin
        @(negedge clk);
        check("inval_remiss", inst_data_ok, 1'b0);
        step();
        wait_ar(a);
        refill(base, 1'b0, 1'b0);
      end
      @(negedge clk);
      check("refill_data", {inst_data_ok, inst_rdata}, {1'b1, exp_word});
      step();
    end
    step();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;

    vt[0]  = mkv(0, 32'h0,         0, 0, 0, 0, 0,  0, 0, 32'h0,  0, 32'h0,         0);
    vt[1]  = mkv(1, 32'h1000_0040, 0, 0, 0, 0, 0,  1, 0, 32'h0,  0, 32'h0,         0);
    vt[2]  = mkv(0, 32'h0,         0, 0, 0, 0, 0,  0, 0, 32'h0,  0, 32'h0,         0);
    vt[3]  = mkv(0, 32'h0,         0, 0, 0, 0, 0,  0, 0, 32'h0,  1, 32'h1000_0040, 0);
    vt[4]  = mkv(0, 32'h0,         1, 0, 0, 0, 0,  0, 0, 32'h0,  1, 32'h1000_0040, 0);
    for (int i = 0; i < LW; i++) begin
      vt[5+i] = mkv(0, 32'h0, 0, 1, 4'd3, 32'hA0 + 32'(i), (i == LW - 1),
                    0, 0, 32'h0, 0, 32'h0, 1);
    end
    vt[13] = mkv(1, 32'h1000_0044, 0, 0, 0, 0, 0,  1, 1, 32'hA0, 0, 32'h0,         0);
    vt[14] = mkv(1, 32'h1000_0048, 0, 0, 0, 0, 0,  1, 1, 32'hA1, 0, 32'h0,         0);
    vt[15] = mkv(0, 32'h0,         0, 0, 0, 0, 0,  0, 1, 32'hA2, 0, 32'h0,         0);
    vt[16] = mkv(0, 32'h0,         0, 0, 0, 0, 0,  0, 0, 32'h0,  0, 32'h0,         0);

    do_reset();

    for (int i = 0; i < 17; i++) begin
      inst_req = vt[i].req; inst_addr = vt[i].addr; arready = vt[i].arready;
      rvalid = vt[i].rvalid; rid = vt[i].rid; rdata = vt[i].rdata; rlast = vt[i].rlast;
      @(negedge clk);
      check($sformatf("vec%0d", i), {inst_addr_ok, inst_data_ok, arvalid, rready, inst_rdata},
            {vt[i].e_addr_ok, vt[i].e_data_ok, vt[i].e_arvalid, vt[i].e_rready, vt[i].e_rdata});
      if (vt[i].e_arvalid) check($sformatf("vec%0d_araddr", i), araddr, vt[i].e_araddr);
      step();
    end
    idle_inputs();
    check("ar_constants", {arid, arlen, arsize, arburst}, {4'd3, 8'd7, 3'd2, 2'b01});
`ifdef ICACHE_PERF_CNT_EN
    check("miss_cnt", miss_cnt, 32'd1);
    check("hit_cnt", hit_cnt, 32'd2);
`else
    check("miss_cnt", miss_cnt, 32'd0);
    check("hit_cnt", hit_cnt, 32'd0);
`endif

    // Round-robin eviction within one set.
    do_reset();
    access(32'h1000_0040, 1, 32'h100, 0, 0);
    access(32'h2000_0040, 1, 32'h200, 0, 0);
    access(32'h3000_0040, 1, 32'h300, 0, 0);
    access(32'h2000_0044, 0, 32'h200, 0, 0);
    access(32'h1000_0040, 1, 32'h400, 0, 0);
    access(32'h3000_004C, 0, 32'h300, 0, 0);

    // Foreign-rid beat must be dropped.
    access(32'h4000_0080, 1, 32'h500, 1, 0);
    access(32'h4000_008C, 0, 32'h500, 0, 0);
    access(32'h4000_009C, 0, 32'h500, 0, 0);

    // Invalidate in IDLE blocks acceptance and drops cached lines.
    inval = 1'b1;
    inst_req = 1'b1;
    inst_addr = 32'h4000_008C;
    @(negedge clk);
    check("inval_idle_addr_ok", inst_addr_ok, 1'b0);
    step();
    idle_inputs();
    access(32'h4000_008C, 1, 32'h600, 0, 0);

    // Invalidate during refill forces a second fetch of the same line.
    do_reset();
    access(32'h1000_0040, 1, 32'h700, 0, 1);

    // Reset in the middle of a burst.
    inst_req = 1'b1;
    inst_addr = 32'h5000_0004;
    step();
    inst_req = 1'b0;
    step();
    wait_ar(32'h5000_0004);
    for (int c = 0; c < 3; c++) begin
      rvalid = 1'b1; rid = 4'd3; rdata = 32'hBAD0 + 32'(c); rlast = 1'b0;
      step();
    end
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_refill", {arvalid, rready, inst_data_ok}, 3'b000);
    step();
    access(32'h5000_0004, 1, 32'h800, 0, 0);
    access(32'h5000_001C, 0, 32'h800, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache_nway_ctrl.md
Name: icache_nway_ctrl

Overview:
- Parametrised N-way set-associative, read-only instruction cache controller; next generation of the 2-way fixed-geometry icache.
- Sits between the CPU fetch stage (sram-like req/addr_ok/data_ok interface) and the AXI read channel.
- Line size, set count, way count and AXI ID are configurable.
- Adds per-set round-robin replacement, rid filtering and whole-cache invalidate.

Parameters:
- LINE_WORDS, 8, 32-bit words per line; power of 2, 2..16.
- SETS, 128, number of sets; power of 2.
- WAYS, 2, associativity; power of 2, 1..8.
- AXI_ID, 3, value driven on arid; only R beats with rid==AXI_ID are accepted.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- inst_req  in  1  fetch request
- inst_addr  in  32  fetch byte address; bits [1:0] ignored
- inst_addr_ok  out  1  request accepted this cycle
- inst_data_ok  out  1  inst_rdata valid this cycle
- inst_rdata  out  32  fetched word
- inval  in  1  invalidate all lines
- arid  out  4  = AXI_ID
- araddr  out  32  line-aligned refill address
- arlen  out  8  = LINE_WORDS-1
- arsize  out  3  = 3'd2
- arburst  out  2  = 2'b01 (INCR)
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  R ID
- rdata  in  32  R data
- rlast  in  1  R last
- rvalid  in  1  R valid
- rready  out  1  R ready
- hit_cnt  out  32  hit counter (see Optional Feature)
- miss_cnt  out  32  miss counter (see Optional Feature)

Behaviour:
- Address split: OFF_W = log2(LINE_WORDS)+2, IDX_W = log2(SETS), tag = addr[31:OFF_W+IDX_W]. Word select = addr[OFF_W-1:2].
- Storage: register arrays for valid, tag and data (WAYS x SETS x LINE_WORDS), read asynchronously. Per-set round-robin pointer of log2(WAYS) bits.
- One outstanding request at a time. Request address is latched into req_addr on addr_ok.
- States: IDLE, LOOKUP, MISS, REFILL.
  - IDLE: inst_addr_ok = inst_req & !inval. On accept, go to LOOKUP.
  - LOOKUP, hit (any way valid with tag match): inst_data_ok=1 and inst_rdata = hit way's word, same cycle. Accept the next req the same cycle (inst_addr_ok = inst_req); stay in LOOKUP if accepted, else go to IDLE. Hit-to-data latency is 1 cycle after addr_ok; back-to-back hits give 1 word/cycle.
  - LOOKUP, miss: inst_addr_ok=0; go to MISS.
  - MISS: arvalid=1, araddr = {req_addr[31:OFF_W], OFF_W'b0}. arvalid stays high until arready is sampled high, then go to REFILL. Victim way = rr_ptr[index], captured on MISS entry.
  - REFILL: rready=1. Each rvalid & rid==AXI_ID beat writes the victim way at word beat_cnt; beat_cnt then increments, wrapping at LINE_WORDS. Beats with other rid are acknowledged but dropped.
  - On the accepted last beat (rlast): set the victim's valid and tag, rr_ptr[index] += 1 (mod WAYS), beat_cnt=0, go to LOOKUP. The request then hits in 1 cycle; refill is not forwarded early.
- inval:
  - In IDLE, or in LOOKUP with no new acceptance: all valid bits clear the next cycle and inst_addr_ok is 0 that cycle.
  - In MISS/REFILL: inval is held pending and applied on return to LOOKUP, before lookup; the in-flight line is then missed again.
- Reset: state=IDLE, all valid=0, all rr_ptr=0, beat_cnt=0. Outputs arvalid, rready, inst_addr_ok, inst_data_ok = 0; inst_rdata=0. Reset mid-refill abandons the burst; the interconnect is reset with the core.
- WAYS=1: rr_ptr is absent and the victim is always way 0.
- Miss and hit checks use only valid ways; multiple matching ways cannot occur.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- Defined: hit_cnt increments on each LOOKUP hit that is not the re-lookup following a refill. miss_cnt increments on each LOOKUP→MISS transition. Both saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: hit_cnt and miss_cnt tied to 0; no counter logic.

Test Plan:
- Defaults, reset, req addr 0x1000_0040 → arvalid=1, araddr=0x1000_0040, arlen=7, arid=3. 8 beats 0xA0..0xA7 with rid=3 → data_ok with rdata=0xA0; miss_cnt=1.
- Same line: back-to-back reqs 0x1000_0044, 0x1000_0048 → data_ok on consecutive cycles, rdata 0xA1, 0xA2; no AR; hit_cnt=2.
- WAYS=2: miss 0x1000_0040, 0x2000_0040, 0x3000_0040 (same index) → third refill evicts way0. Re-access 0x1000_0040 → new AR issued.
- Refill with an interleaved beat rid=5 → beat ignored, line holds only rid=3 data, rready stays 1.
- inval asserted during REFILL of 0x1000_0040 → after rlast, LOOKUP misses and a second AR is issued for 0x1000_0040.
- rst asserted mid-refill (after 3 beats) → next cycle arvalid=0, rready=0, state IDLE. Re-request of the same address misses.
